// File: rtl/vga_pkg.sv
// Shared constants, colour type and overlay record for the VGA pixel pipeline.
package vga_pkg;

    localparam int unsigned H_ACTIVE   = 640;
    localparam int unsigned V_ACTIVE   = 480;
    localparam int unsigned FB_LATENCY = 2;
    localparam int unsigned SYNC_LAG   = 1;
    localparam int unsigned BOX_THICK  = 2;
    localparam int unsigned CROSS_LEN  = 8;
    localparam int unsigned COORD_W    = 10;

    // 12-bit {R,G,B}, 4 bits per channel
    typedef logic [11:0] rgb444_t;

    localparam rgb444_t BOX_COLOR   = 12'hF00;
    localparam rgb444_t CROSS_COLOR = 12'h0F0;

    // Colour bars, left to right
    localparam rgb444_t COLOR_BAR [0:7] = '{
        12'hFFF,  // white
        12'hFF0,  // yellow
        12'h0FF,  // cyan
        12'h0F0,  // green
        12'hF0F,  // magenta
        12'hF00,  // red
        12'h00F,  // blue
        12'h000   // black
    };

    // Overlay description as written by the gesture detector
    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] cx;
        logic [COORD_W-1:0] cy;
        logic               valid;
    } overlay_cfg_t;

endpackage

// File: rtl/vga_delay_line.sv
// Reset-clearable shift register used to align pixel tags and syncs with frame-buffer data.
module vga_delay_line #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Each stage takes the one before it; stage 0 takes the input
    always_comb begin
        stage_d[0] = d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers, cleared to RESET_VAL
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipeline.sv
// VGA output stage: aligns syncs with frame-buffer data, overlays the detector box and
// centroid crosshair (double-buffered per frame), and registers the connector pins.
module vga_pixel_pipeline
    import vga_pkg::*;
#(
    parameter int unsigned FB_LAT    = FB_LATENCY,
    parameter int unsigned SYNC_LAGC = SYNC_LAG,
    parameter int unsigned THICK     = BOX_THICK,
    parameter int unsigned ARM_LEN   = CROSS_LEN,
    parameter rgb444_t     BOX_COL   = BOX_COLOR,
    parameter rgb444_t     CROSS_COL = CROSS_COLOR
) (
    input  logic        clk_25mhz,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        active_in,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic [11:0] fb_rdata,
    input  logic        pattern_en,
    input  logic        box_wr,
    input  logic [9:0]  box_x0,
    input  logic [9:0]  box_y0,
    input  logic [9:0]  box_x1,
    input  logic [9:0]  box_y1,
    input  logic [9:0]  cen_x,
    input  logic [9:0]  cen_y,
    input  logic        obj_valid,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        frame_start
);

    // Syncs already lag x/y, so they need that much less delay to meet the colour
    localparam int unsigned SYNC_DEPTH = FB_LAT + 1 - SYNC_LAGC;

    localparam logic [9:0]        THICK_W   = 10'(THICK);
    localparam logic signed [10:0] ARM_W    = 11'(ARM_LEN);
    localparam logic [9:0]        COMMIT_Y  = 10'(V_ACTIVE);

    // ---------------------------------------------------------------------------------------
    // Alignment delay lines
    // ---------------------------------------------------------------------------------------
    logic [20:0] pix_tag_in;
    logic [20:0] pix_tag_s;
    logic        act_s;
    logic [9:0]  x_s;
    logic [9:0]  y_s;
    logic [1:0]  sync_s;

    assign pix_tag_in = {active_in, x_pos, y_pos};
    assign act_s      = pix_tag_s[20];
    assign x_s        = pix_tag_s[19:10];
    assign y_s        = pix_tag_s[9:0];

    vga_delay_line #(
        .WIDTH     (21),
        .DEPTH     (FB_LAT),
        .RESET_VAL ('0)
    ) u_pix_dly (
        .clk_i  (clk_25mhz),
        .rst_ni (rst_n),
        .d_i    (pix_tag_in),
        .q_o    (pix_tag_s)
    );

    // Last stage of this line is the registered sync pin pair
    vga_delay_line #(
        .WIDTH     (2),
        .DEPTH     (SYNC_DEPTH),
        .RESET_VAL (2'b11)
    ) u_sync_dly (
        .clk_i  (clk_25mhz),
        .rst_ni (rst_n),
        .d_i    ({hsync_in, vsync_in}),
        .q_o    (sync_s)
    );

    assign vga_hsync = sync_s[1];
    assign vga_vsync = sync_s[0];

    // ---------------------------------------------------------------------------------------
    // Staging / shadow registers
    // ---------------------------------------------------------------------------------------
    overlay_cfg_t stage_q, stage_d;
    overlay_cfg_t shadow_q, shadow_d;
    logic         pending_q, pending_d;
    logic         pat_q, pat_d;
    logic         is_commit;

    // First pixel of the first blanking line: nothing visible is in flight
    assign is_commit   = (x_pos == 10'd0) && (y_pos == COMMIT_Y);
    assign frame_start = is_commit && rst_n;

    // Commit copies the old staging; a write on the same cycle stays pending
    always_comb begin
        stage_d   = stage_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pat_d     = pat_q;
        if (is_commit) begin
            pat_d = pattern_en;
            if (pending_q) begin
                shadow_d  = stage_q;
                pending_d = 1'b0;
            end
        end
        if (box_wr) begin
            stage_d   = '{x0: box_x0, y0: box_y0, x1: box_x1, y1: box_y1,
                          cx: cen_x, cy: cen_y, valid: obj_valid};
            pending_d = 1'b1;
        end
    end

    // Staging and shadow state
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            stage_q   <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            pat_q     <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pat_q     <= pat_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Overlay and colour selection on the delayed pixel
    // ---------------------------------------------------------------------------------------
    logic             box_ok;
    logic             in_box;
    logic             near_edge;
    logic             box_edge;
    logic             on_cross;
    logic [9:0]       d_left, d_right, d_top, d_bot;
    logic signed [10:0] dx_c, dy_c;
    rgb444_t          src_pix;
    rgb444_t          pix_col;
    rgb444_t          rgb_q, rgb_d;

    // Box edge, crosshair and source pixel, highest priority first
    always_comb begin
        box_ok  = shadow_q.valid && (shadow_q.x0 <= shadow_q.x1) && (shadow_q.y0 <= shadow_q.y1);
        in_box  = (x_s >= shadow_q.x0) && (x_s <= shadow_q.x1) &&
                  (y_s >= shadow_q.y0) && (y_s <= shadow_q.y1);
        // Only meaningful inside the box, where none of these underflow
        d_left    = x_s - shadow_q.x0;
        d_right   = shadow_q.x1 - x_s;
        d_top     = y_s - shadow_q.y0;
        d_bot     = shadow_q.y1 - y_s;
        near_edge = (d_left < THICK_W) || (d_right < THICK_W) ||
                    (d_top < THICK_W) || (d_bot < THICK_W);
        box_edge  = box_ok && in_box && near_edge;

        // Signed 11-bit differences so arms clip at the screen edge instead of wrapping
        dx_c     = $signed({1'b0, x_s}) - $signed({1'b0, shadow_q.cx});
        dy_c     = $signed({1'b0, y_s}) - $signed({1'b0, shadow_q.cy});
        on_cross = shadow_q.valid &&
                   (((y_s == shadow_q.cy) && (dx_c >= -ARM_W) && (dx_c <= ARM_W)) ||
                    ((x_s == shadow_q.cx) && (dy_c >= -ARM_W) && (dy_c <= ARM_W)));

        src_pix = pat_q ? COLOR_BAR[x_s[8:6]] : fb_rdata;

        if (box_edge) begin
            pix_col = BOX_COL;
        end else if (on_cross) begin
            pix_col = CROSS_COL;
        end else begin
            pix_col = src_pix;
        end

        rgb_d = act_s ? pix_col : '0;
    end

    // Registered colour pins
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];

endmodule
